pipeline_hazard_controller: RTL

- Parametrised successor to the fixed 4-latch pipeline controller.
- Drives per-latch enable/flush vectors and a PC enable for an N-latch in-order pipeline.
- Adds an FSM for split I/D memory waits, load-use bubble insertion with a programmable bubble count, taken-branch squash, sticky halt, and a stall-cycle counter.
- Sits between the datapath's hazard sources (caches, decode, EX branch resolve) and all pipeline latches.

---
 rtl/pipeline_hazard_controller.sv | 108 ++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: per-latch enable/flush and PC control for an N-latch in-order pipeline,
// covering split I/D memory waits, load-use bubbles, branch squash, sticky halt and a stall counter.
module pipeline_hazard_controller #(
    parameter int NLATCH     = 4,
    parameter int REGW       = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNTW       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic              ex_memtoreg,
    input  logic [REGW-1:0]   ex_rd,
    input  logic              branch_taken,
    input  logic              halt,
    output logic [NLATCH-1:0] enable,
    output logic [NLATCH-1:0] flush,
    output logic              pc_enable,
    output logic              halted,
    output logic [CNTW-1:0]   stall_cycles
);
    typedef enum logic [2:0] {RUN, DWAIT, IWAIT, LUSTALL, HALTED} state_t;
    localparam logic [NLATCH-1:0] LAST  = {1'b1, {(NLATCH-1){1'b0}}};
    localparam logic [NLATCH-1:0] PRE   = LAST >> 1;
    localparam logic [NLATCH-1:0] FL0   = NLATCH'(1);
    localparam logic [NLATCH-1:0] BR_FL = NLATCH'(3);
    localparam logic [NLATCH-1:0] LU_FL = NLATCH'(2);
    localparam logic [NLATCH-1:0] LU_EN = ~FL0;
    state_t state, next_state;
    logic [2:0] lu_cnt, next_cnt;
    logic ihit_pend, next_pend;
    logic [NLATCH-1:0] en, fl;
    logic pc, dreq, lu, run_like, dwait_now, dresolve, ih, lu_mode;
    // lu_cnt stays non-zero across a data/instruction wait that interrupted a load-use stall,
    // so the stall resumes once the wait resolves.
    always_comb begin
        dreq = dmemREN | dmemWEN;
        lu = ex_memtoreg && ex_rd != '0 && (ex_rd == id_rs || ex_rd == id_rt);
        run_like = state == RUN || state == LUSTALL;
        dwait_now = state == DWAIT ? !dhit : run_like && dreq && !dhit;
        dresolve = state == DWAIT ? dhit : run_like && dreq && dhit;
        ih = ihit || (state == DWAIT && ihit_pend);
        lu_mode = lu_cnt != '0;
        en = '1;
        fl = '0;
        pc = 1'b0;
        next_state = state;
        next_cnt = lu_cnt;
        next_pend = 1'b0;
        if (state == HALTED) begin
            en = '0;
        end else if (dwait_now) begin
            en = '0;
            next_pend = ihit || (state == DWAIT && ihit_pend);
            next_state = DWAIT;
        end else if (dresolve && !ih) begin
            en = LAST;
            fl = PRE;
            next_state = IWAIT;
        end else if (state == IWAIT && !ihit) begin
            en = LAST;
            fl = LAST;
        end else if (!ih) begin
            en = lu_mode ? LU_EN : '1;
            fl = lu_mode ? LU_FL : FL0;
        end else if (branch_taken) begin
            fl = BR_FL;
            pc = 1'b1;
            next_cnt = '0;
            next_state = RUN;
        end else if (lu_mode || lu) begin
            en = LU_EN;
            fl = LU_FL;
            next_cnt = lu_mode ? lu_cnt - 3'd1 : 3'(LU_BUBBLES - 1);
            next_state = next_cnt != '0 ? LUSTALL : RUN;
        end else begin
            pc = 1'b1;
            next_state = RUN;
        end
        if (halt && ih && state != HALTED && !dwait_now) begin
            next_state = HALTED;
            next_cnt = '0;
        end
    end
    assign enable = RST ? '0 : en;
    assign flush = RST ? '1 : fl;
    assign pc_enable = RST ? 1'b0 : pc;
    assign halted = !RST && state == HALTED;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            lu_cnt <= '0;
            ihit_pend <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= next_state;
            lu_cnt <= next_cnt;
            ihit_pend <= next_pend;
            if (!pc && state != HALTED && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule
